// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video types: colour width default, mux FSM states, source slice helper
package video_pkg;

    localparam int COLOR_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        FADE_OUT,
        SWAP,
        FADE_IN
    } mux_state_t;

    // Low bit of source idx inside a packed {src[N-1], ..., src[0]} colour bus.
    function automatic int src_slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchroniser, level debounce and one-cycle press pulse for an active-low key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level;
    // any sample that agrees again restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/screen_mux.sv
// rtl/screen_mux.sv - frame-synchronous N-source video selector; SCREEN_MUX_FADE_EN adds fade-to-black
module screen_mux
    import video_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int COLOR_W         = COLOR_W_DEF,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_next_n,
    input  logic                       key_prev_n,
    input  logic                       frame_start,
    input  logic                       disp_en,
    input  logic [NUM_SRC*COLOR_W-1:0] src_r,
    input  logic [NUM_SRC*COLOR_W-1:0] src_g,
    input  logic [NUM_SRC*COLOR_W-1:0] src_b,
    output logic [COLOR_W-1:0]         r,
    output logic [COLOR_W-1:0]         g,
    output logic [COLOR_W-1:0]         b,
    output logic [$clog2(NUM_SRC)-1:0] sel,
    output logic [NUM_SRC-1:0]         src_enable,
    output logic                       busy
);

    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int SH_W  = $clog2(COLOR_W + 1);

    mux_state_t       state;
    mux_state_t       state_d;
    logic [SEL_W-1:0] target;
    logic [SEL_W-1:0] sel_inc;
    logic [SEL_W-1:0] sel_dec;
    logic             press_next;
    logic             press_prev;
    logic             ev_next;
    logic             ev_any;
    logic             take_req;
    logic             load_sel;
    logic [SH_W-1:0]  shift;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_next_n),
        .press (press_next)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_prev_n),
        .press (press_prev)
    );

    // Simultaneous presses cancel each other.
    assign ev_next  = press_next & ~press_prev;
    assign ev_any   = press_next ^ press_prev;
    assign take_req = (state == IDLE) && ev_any;

    assign sel_inc = (sel == SEL_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
    assign sel_dec = (sel == '0) ? SEL_W'(NUM_SRC - 1) : sel - 1'b1;

`ifdef SCREEN_MUX_FADE_EN
    logic shift_up;
    logic shift_dn;

    always_comb begin
        state_d  = state;
        load_sel = 1'b0;
        shift_up = 1'b0;
        shift_dn = 1'b0;
        case (state)
            IDLE:     if (take_req) state_d = FADE_OUT;
            FADE_OUT: if (frame_start) begin
                shift_up = 1'b1;
                if (shift == SH_W'(COLOR_W - 1)) state_d = SWAP;
            end
            SWAP:     if (frame_start) begin
                load_sel = 1'b1;
                state_d  = FADE_IN;
            end
            FADE_IN:  if (frame_start) begin
                shift_dn = 1'b1;
                if (shift == SH_W'(1)) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else if (shift_up) begin
            shift <= shift + 1'b1;
        end else if (shift_dn) begin
            shift <= shift - 1'b1;
        end
    end
`else
    assign shift = '0;

    always_comb begin
        state_d  = state;
        load_sel = 1'b0;
        case (state)
            IDLE:       if (take_req) state_d = WAIT_FRAME;
            WAIT_FRAME: if (frame_start) begin
                load_sel = 1'b1;
                state_d  = IDLE;
            end
            default:    state_d = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            target <= '0;
        end else begin
            state <= state_d;
            if (take_req) target <= ev_next ? sel_inc : sel_dec;
            if (load_sel) sel <= target;
        end
    end

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SEL_W'(i) == sel) begin
                pix_r = src_r[src_slice_lo(i, COLOR_W) +: COLOR_W];
                pix_g = src_g[src_slice_lo(i, COLOR_W) +: COLOR_W];
                pix_b = src_b[src_slice_lo(i, COLOR_W) +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= disp_en ? (pix_r >> shift) : '0;
            g <= disp_en ? (pix_g >> shift) : '0;
            b <= disp_en ? (pix_b >> shift) : '0;
        end
    end

    assign src_enable = NUM_SRC'(1) << sel;
    assign busy       = (state != IDLE);

endmodule
